// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the control unit that drives it:
// the default datapath width and the 3-bit operation codes.
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_datapath.sv
// Combinational core of the ALU: selects one of eight operations and
// derives the zero flag from that same next result, so the registered
// result and flag can never disagree.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Operation select; unsigned arithmetic wraps and carry/borrow are dropped.
    always_comb begin
        result = '0;
        case (sel)
            ALU_ADD: result = in1 + in2;
            ALU_SUB: result = in1 - in2;
            ALU_AND: result = in1 & in2;
            ALU_OR:  result = in1 | in2;
            ALU_XOR: result = in1 ^ in2;
            ALU_NOT: result = ~in1;
            ALU_SHL: result = {in1[WIDTH-2:0], 1'b0};
            ALU_SHR: result = {1'b0, in1[WIDTH-1:1]};
            default: result = '0;
        endcase
    end

    // Zero flag follows the next result, not the currently registered one.
    always_comb begin
        zero = (result == '0);
    end

endmodule : alu_datapath

// File: rtl/alu_unit.sv
// Registered ALU: the combinational datapath feeds one bank of output
// registers, giving exactly one cycle of latency and no combinational
// path from operands to outputs. Reset clears the result and raises Z.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             Z
);

    logic [WIDTH-1:0] next_result;
    logic             next_zero;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .in1    (in1),
        .in2    (in2),
        .sel    (sel),
        .result (next_result),
        .zero   (next_zero)
    );

    // Capture a new result every edge; reset discards any in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            Z   <= 1'b1;
        end else begin
            out <= next_result;
            Z   <= next_zero;
        end
    end

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver pushes the reference result
// for each operand set it applies, and a monitor pops and compares after
// every rising edge while out of reset.
module tb_alu_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [2:0]   sel = '0;
    logic [W-1:0] out;
    logic         Z;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int    res;
        bit    zf;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    alu_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .sel   (sel),
        .out   (out),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic modulo 256.
    function automatic int model(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 255 - a;
            6: return (a * 2) % 256;
            default: return a / 2;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Apply one operation at the falling edge and queue its expected result.
    task automatic drive(input int a, input int b, input int op, input string tag);
        exp_t e;
        @(negedge clk);
        in1 = a[W-1:0];
        in2 = b[W-1:0];
        sel = op[2:0];
        e.res = model(a, b, op);
        e.zf  = (e.res == 0);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare registered outputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".out"}, int'(out), e.res);
            check({e.tag, ".Z"}, int'(Z), int'(e.zf));
        end
    end

    initial begin
        // Held reset with random operands: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in1 = W'($urandom);
            in2 = W'($urandom);
            sel = 3'($urandom);
            #7;
            check("reset_hold.out", int'(out), 0);
            check("reset_hold.Z", int'(Z), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        drive(2, 4, 0, "add_2_4");
        drive(5, 3, 0, "add_5_3");
        drive(1, 3, 4, "xor_1_3");
        drive(3, 3, 1, "sub_3_3");
        drive(1, 3, 1, "sub_1_3");
        drive(200, 100, 0, "add_200_100");
        drive(128, 128, 0, "add_128_128");
        drive(8'hA5, 8'h0F, 2, "and_a5");
        drive(8'hA5, 8'h0F, 3, "or_a5");
        drive(8'hA5, 8'h0F, 5, "not_a5");
        drive(8'hA5, 8'h0F, 6, "shl_a5");
        drive(8'hA5, 8'h0F, 7, "shr_a5");
        drive(0, 0, 0, "add_zero");
        drive(255, 1, 0, "add_wrap");
        drive(0, 1, 1, "sub_wrap");
        drive(255, 0, 5, "not_ff");
        drive(1, 0, 7, "shr_one");
        drive(128, 0, 6, "shl_msb");

        // Operation changes every cycle, back to back.
        for (int op = 0; op < 8; op++)
            drive($urandom_range(0, 255), $urandom_range(0, 255), op, "latency_sweep");

        // Randomized stream.
        for (int i = 0; i < 200; i++)
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), "random");

        // Mid-stream reset: a nonzero result is showing and one is in flight.
        drive(2, 4, 0, "pre_reset");
        drive(9, 9, 0, "in_flight");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset.out", int'(out), 0);
        check("async_reset.Z", int'(Z), 1);
        @(posedge clk);
        #1;
        check("reset_edge.out", int'(out), 0);
        check("reset_edge.Z", int'(Z), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), "post_reset");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d results left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_alu_unit
